trigger_capture_buffer: RTL and testbench
=========================================

# trigger_capture_buffer

Two-bank, multi-channel sample capture buffer for the oscilloscope with a runtime-programmable pretrigger depth and single-shot / continuous capture modes. It sits between the ADC sample stream (with trigger detector) and the display/readout logic. Samples are written into the active bank around a trigger event; the completed frame is handed to the display by swapping banks under a ready/acknowledge handshake. The display reads the locked bank addressed relative to the trigger sample.

## Interface
Parameters:
- LOG_SAMPLES, 12, log2 of frame depth (N = 2^LOG_SAMPLES samples per channel per bank)
- SAMPLE_SIZE, 12, bits per signed sample
- CHANNELS, 2, channels captured in lockstep (>=1)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- ready  in  1  sample strobe; dataIn valid this cycle
- dataIn  in  CHANNELS*SAMPLE_SIZE  packed signed samples, channel 0 in LSBs
- isTrigger  in  1  trigger qualifier for the sample presented with ready
- arm  in  1  one-cycle pulse; starts capture from IDLE
- stop  in  1  one-cycle pulse; aborts capture, returns to IDLE
- singleShot  in  1  1: one frame then IDLE; 0: re-arm automatically
- pretrigger  in  LOG_SAMPLES  samples kept before trigger; latched at arm and each re-arm
- swapAck  in  1  display finished with locked frame
- readChannel  in  max(1,$clog2(CHANNELS))  channel to read
- readAddress  in  LOG_SAMPLES signed  offset from trigger sample
- dataOut  out  SAMPLE_SIZE signed  registered read data from locked bank
- captureState  out  3  current state encoding
- frameReady  out  1  locked bank holds an unacknowledged complete frame

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- IDLE: no writes. arm -> latch pretrigger as P, clear sample counter, go PRE (ARMED directly if P==0).
- PRE: each ready writes all channels at writePtr, writePtr++, count++; when count reaches P go ARMED. isTrigger ignored.
- ARMED: each ready writes. If isTrigger && ready: this sample is the trigger sample, trigAddr <= writePtr, postCount <= 0; go POST, or DONE if P==N-1.
- POST: each ready writes, postCount++; after N-1-P post-trigger samples go DONE.
- DONE: no writes. When frameReady==0: toggle activeBank, lockedTrig <= trigAddr, frameReady <= 1; then singleShot ? IDLE : PRE (P re-latched, count cleared).
- swapAck clears frameReady; swapAck while frameReady==0 is a no-op.
- Frame layout: offsets -P..-1 pretrigger, 0 trigger, 1..N-1-P post; all modulo N.
- Read: locked bank address = (lockedTrig + readAddress) mod N; dataOut = selected channel of that word. readChannel >= CHANNELS returns 0.
- Boundaries: writePtr wraps N-1 -> 0; ready low stalls all counters; arm outside IDLE ignored; stop in any state -> IDLE next cycle, partial frame discarded, locked bank/frameReady untouched; stop and arm same cycle: stop wins; swapAck same cycle as DONE check: DONE sees old frameReady, swaps one cycle later.
- Reset: state IDLE, activeBank 0, writePtr/trigAddr/lockedTrig/counters 0, frameReady 0, dataOut 0, captureState IDLE.

## Timing
- Write: sample with ready at cycle t lands in BRAM at t+1.
- Trigger to trigAddr: 1 cycle.
- Read latency 3 cycles: readAddress/readChannel at t -> address register t+1 -> BRAM output t+2 -> dataOut t+3. Fully pipelined, one read per cycle.
- Swap: frameReady rises the cycle after DONE with frameReady==0; reads issued that cycle or later see the new frame.
- captureState is a registered copy of the state, no lag beyond the register.

## Structure
- Shared package osc_pkg: capture state enum (IDLE=0, PRE=1, ARMED=2, POST=3, DONE=4) and its width constant.
- Sub-module sample_bram: simple dual-port, one write port, one registered read port, width CHANNELS*SAMPLE_SIZE, depth N; instantiated twice (bank 0/1), write enable gated by activeBank.

## Test plan
- LOG_SAMPLES=4, P=4, ramp data 0,1,2..., trigger on sample 20 -> frameReady after 11 more samples; reading offsets -4..11 yields 16..31.
- P=0 and P=15 -> trigger sample at offset 0 and offset 15 respectively; P=15 goes DONE on trigger cycle+1.
- Triggers during PRE (samples 1-3 with P=4) ignored; first trigger after 4 samples captured.
- Continuous mode, no swapAck -> stays in DONE, locked frame unchanged; swapAck -> swap within 2 cycles, next frame captured.
- stop during POST -> IDLE, frameReady and old readout unchanged; reset mid-POST -> all outputs 0, IDLE.
- CHANNELS=2, ch1 = -ch0 -> readChannel 1 returns negated values, 3-cycle latency checked.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared capture-FSM definitions for the oscilloscope sample path.
// No logic: state encoding, its width and a small entry-state helper.
// No flow control of its own.
package osc_pkg;

  localparam int CAP_STATE_W = 3;

  typedef enum logic [CAP_STATE_W-1:0] {
    CAP_IDLE  = 3'd0,
    CAP_PRE   = 3'd1,
    CAP_ARMED = 3'd2,
    CAP_POST  = 3'd3,
    CAP_DONE  = 3'd4
  } cap_state_e;

  // With no pretrigger history to collect, capture starts already armed.
  function automatic cap_state_e capture_entry_state(input logic pre_is_zero);
    return pre_is_zero ? CAP_ARMED : CAP_PRE;
  endfunction

endpackage

// File: rtl/sample_bram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// Write visible the cycle after wr_en; read data one cycle after rd_addr.
// No backpressure: accepts a write and a read every cycle.
module sample_bram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_dat_q;

  // Block-RAM style storage: contents are not reset, read port is registered.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
    rd_dat_q <= mem_q[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/trigger_capture_buffer.sv
// Two-bank multi-channel capture buffer with pretrigger history and bank swap.
// Write lands one cycle after ready; read data appears 3 cycles after address.
// Sample stream is never stalled; a finished frame waits in DONE until the display acks.
module trigger_capture_buffer
  import osc_pkg::*;
#(
  parameter int LOG_SAMPLES = 12,
  parameter int SAMPLE_SIZE = 12,
  parameter int CHANNELS    = 2,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                ready,
  input  logic [CHANNELS*SAMPLE_SIZE-1:0]     dataIn,
  input  logic                                isTrigger,
  input  logic                                arm,
  input  logic                                stop,
  input  logic                                singleShot,
  input  logic [LOG_SAMPLES-1:0]              pretrigger,
  input  logic                                swapAck,
  input  logic [CH_W-1:0]                     readChannel,
  input  logic signed [LOG_SAMPLES-1:0]       readAddress,
  output logic signed [SAMPLE_SIZE-1:0]       dataOut,
  output logic [CAP_STATE_W-1:0]              captureState,
  output logic                                frameReady
);

  localparam int DATA_W = CHANNELS * SAMPLE_SIZE;
  localparam logic [LOG_SAMPLES-1:0] PTR_ONE  = LOG_SAMPLES'(1);
  localparam logic [LOG_SAMPLES-1:0] PTR_LAST = {LOG_SAMPLES{1'b1}};

  // capture-side state
  cap_state_e             state_q, state_d;
  logic                   active_bank_q, active_bank_d;
  logic [LOG_SAMPLES-1:0] write_ptr_q, write_ptr_d;
  logic [LOG_SAMPLES-1:0] trig_addr_q, trig_addr_d;
  logic [LOG_SAMPLES-1:0] locked_trig_q, locked_trig_d;
  logic [LOG_SAMPLES-1:0] pre_count_q, pre_count_d;
  logic [LOG_SAMPLES-1:0] post_count_q, post_count_d;
  logic [LOG_SAMPLES-1:0] pre_len_q, pre_len_d;
  logic                   frame_ready_q, frame_ready_d;
  logic                   wr_en;
  logic [LOG_SAMPLES-1:0] post_target;

  // read-side pipeline
  logic [LOG_SAMPLES-1:0] rd_addr_q, rd_addr_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [CH_W-1:0]        rd_chan_q, rd_chan_d;
  logic                   rd_vld_q, rd_vld_d;
  logic                   rd_bank2_q, rd_bank2_d;
  logic [CH_W-1:0]        rd_chan2_q, rd_chan2_d;
  logic                   rd_vld2_q, rd_vld2_d;
  logic [SAMPLE_SIZE-1:0] data_out_q, data_out_d;
  logic [DATA_W-1:0]      bank0_rd, bank1_rd, sel_word;
  logic [SAMPLE_SIZE-1:0] sel_sample;

  // Post-trigger samples still needed after the trigger: N-1-P.
  assign post_target = PTR_LAST - pre_len_q;

  // Capture FSM: decides writes, pointer movement, trigger capture and bank swap.
  always_comb begin
    state_d       = state_q;
    active_bank_d = active_bank_q;
    write_ptr_d   = write_ptr_q;
    trig_addr_d   = trig_addr_q;
    locked_trig_d = locked_trig_q;
    pre_count_d   = pre_count_q;
    post_count_d  = post_count_q;
    pre_len_d     = pre_len_q;
    frame_ready_d = frame_ready_q;
    wr_en         = 1'b0;

    if (stop) begin
      // Abort discards the partial frame only; the locked bank is untouched.
      state_d = CAP_IDLE;
    end else begin
      case (state_q)
        CAP_IDLE: begin
          if (arm) begin
            pre_len_d   = pretrigger;
            pre_count_d = '0;
            state_d     = capture_entry_state(pretrigger == '0);
          end
        end
        CAP_PRE: begin
          if (ready) begin
            wr_en       = 1'b1;
            write_ptr_d = write_ptr_q + PTR_ONE;
            pre_count_d = pre_count_q + PTR_ONE;
            if (pre_count_q + PTR_ONE == pre_len_q) begin
              state_d = CAP_ARMED;
            end
          end
        end
        CAP_ARMED: begin
          if (ready) begin
            wr_en       = 1'b1;
            write_ptr_d = write_ptr_q + PTR_ONE;
            if (isTrigger) begin
              trig_addr_d  = write_ptr_q;
              post_count_d = '0;
              state_d      = (pre_len_q == PTR_LAST) ? CAP_DONE : CAP_POST;
            end
          end
        end
        CAP_POST: begin
          if (ready) begin
            wr_en        = 1'b1;
            write_ptr_d  = write_ptr_q + PTR_ONE;
            post_count_d = post_count_q + PTR_ONE;
            if (post_count_q + PTR_ONE == post_target) begin
              state_d = CAP_DONE;
            end
          end
        end
        CAP_DONE: begin
          // Hand over only once the display has released the previous frame.
          if (!frame_ready_q) begin
            active_bank_d = ~active_bank_q;
            locked_trig_d = trig_addr_q;
            frame_ready_d = 1'b1;
            if (singleShot) begin
              state_d = CAP_IDLE;
            end else begin
              pre_len_d   = pretrigger;
              pre_count_d = '0;
              state_d     = capture_entry_state(pretrigger == '0);
            end
          end
        end
        default: state_d = CAP_IDLE;
      endcase
    end

    // Ack only matters while a frame is held; DONE sets the flag only when it is clear.
    if (swapAck && frame_ready_q) begin
      frame_ready_d = 1'b0;
    end
  end

  // Capture-side registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= CAP_IDLE;
      active_bank_q <= 1'b0;
      write_ptr_q   <= '0;
      trig_addr_q   <= '0;
      locked_trig_q <= '0;
      pre_count_q   <= '0;
      post_count_q  <= '0;
      pre_len_q     <= '0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      active_bank_q <= active_bank_d;
      write_ptr_q   <= write_ptr_d;
      trig_addr_q   <= trig_addr_d;
      locked_trig_q <= locked_trig_d;
      pre_count_q   <= pre_count_d;
      post_count_q  <= post_count_d;
      pre_len_q     <= pre_len_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  sample_bram #(.ADDR_W(LOG_SAMPLES), .DATA_W(DATA_W)) u_bank0 (
    .clock   (clock),
    .wr_en   (wr_en & ~active_bank_q),
    .wr_addr (write_ptr_q),
    .wr_dat  (dataIn),
    .rd_addr (rd_addr_q),
    .rd_dat  (bank0_rd)
  );

  sample_bram #(.ADDR_W(LOG_SAMPLES), .DATA_W(DATA_W)) u_bank1 (
    .clock   (clock),
    .wr_en   (wr_en & active_bank_q),
    .wr_addr (write_ptr_q),
    .wr_dat  (dataIn),
    .rd_addr (rd_addr_q),
    .rd_dat  (bank1_rd)
  );

  // Read pipeline: trigger-relative address, bank/channel carried alongside the RAM read.
  always_comb begin
    rd_addr_d  = locked_trig_q + $unsigned(readAddress);
    rd_bank_d  = ~active_bank_q;
    rd_chan_d  = readChannel;
    rd_vld_d   = 1'b1;
    rd_bank2_d = rd_bank_q;
    rd_chan2_d = rd_chan_q;
    rd_vld2_d  = rd_vld_q;

    sel_word   = rd_bank2_q ? bank1_rd : bank0_rd;
    sel_sample = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_chan2_q == CH_W'(c)) begin
        sel_sample = sel_word[c*SAMPLE_SIZE +: SAMPLE_SIZE];
      end
    end
    // Until the pipeline refills after reset the RAM word is meaningless; show zero.
    data_out_d = rd_vld2_q ? sel_sample : '0;
  end

  // Read pipeline registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
      rd_chan_q  <= '0;
      rd_vld_q   <= 1'b0;
      rd_bank2_q <= 1'b0;
      rd_chan2_q <= '0;
      rd_vld2_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      rd_addr_q  <= rd_addr_d;
      rd_bank_q  <= rd_bank_d;
      rd_chan_q  <= rd_chan_d;
      rd_vld_q   <= rd_vld_d;
      rd_bank2_q <= rd_bank2_d;
      rd_chan2_q <= rd_chan2_d;
      rd_vld2_q  <= rd_vld2_d;
      data_out_q <= data_out_d;
    end
  end

  assign dataOut      = data_out_q;
  assign captureState = state_q;
  assign frameReady   = frame_ready_q;

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Bench for trigger_capture_buffer at 16 samples x 2 channels x 12 bits.
// Read expectations are queued at issue time and compared three cycles later.
// Capture stimulus is a ramp (ch1 = -ch0) with optional ready-low gaps.
module tb_trigger_capture_buffer;

  localparam int LOG = 4;
  localparam int SS  = 12;
  localparam int CH  = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              ready;
  logic [CH*SS-1:0]  dataIn;
  logic              isTrigger;
  logic              arm;
  logic              stop;
  logic              singleShot;
  logic [LOG-1:0]    pretrigger;
  logic              swapAck;
  logic [0:0]        readChannel;
  logic signed [LOG-1:0] readAddress;
  logic signed [SS-1:0]  dataOut;
  logic [2:0]        captureState;
  logic              frameReady;

  trigger_capture_buffer #(.LOG_SAMPLES(LOG), .SAMPLE_SIZE(SS), .CHANNELS(CH)) dut (
    .clock        (clock),
    .reset        (reset),
    .ready        (ready),
    .dataIn       (dataIn),
    .isTrigger    (isTrigger),
    .arm          (arm),
    .stop         (stop),
    .singleShot   (singleShot),
    .pretrigger   (pretrigger),
    .swapAck      (swapAck),
    .readChannel  (readChannel),
    .readAddress  (readAddress),
    .dataOut      (dataOut),
    .captureState (captureState),
    .frameReady   (frameReady)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int samp     = 0;

  typedef struct {
    logic [SS-1:0] val;
    int            due;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t cur_e;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Pop and compare read results that are due on this cycle.
  always @(negedge clock) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      cur_e = exp_q.pop_front();
      if (cur_e.due == cyc) chk("rd_data", 32'($unsigned(dataOut)), 32'(cur_e.val));
      else                  chk("rd_late", 32'(cur_e.due), 32'(cyc));
    end
  end

  // Drive a stream of n ramp samples; trigger qualifier high for values in [tlo,thi].
  task automatic send(input int n, input int tlo, input int thi, input bit gaps);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (gaps && $urandom_range(0, 3) == 0) begin
        ready     = 1'b0;
        dataIn    = 24'($urandom);
        isTrigger = 1'b1;
        @(negedge clock);
      end
      ready     = 1'b1;
      dataIn    = {12'(-samp), 12'(samp)};
      isTrigger = (samp >= tlo) && (samp <= thi);
      samp++;
    end
    @(negedge clock);
    ready     = 1'b0;
    isTrigger = 1'b0;
  endtask

  // Read offsets lo..hi on both channels; frame value at offset o is trig+o.
  task automatic read_frame(input int trig, input int lo, input int hi);
    rd_exp_t e;
    for (int o = lo; o <= hi; o++) begin
      for (int c = 0; c < CH; c++) begin
        @(negedge clock);
        readAddress = LOG'(o);
        readChannel = 1'(c);
        e.val = (c == 0) ? SS'(trig + o) : SS'(-(trig + o));
        e.due = cyc + 3;
        exp_q.push_back(e);
      end
    end
    repeat (4) @(negedge clock);
    chk("rd_drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_arm(input int p);
    @(negedge clock);
    pretrigger = LOG'(p);
    arm        = 1'b1;
    @(negedge clock);
    arm        = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clock);
    swapAck = 1'b1;
    @(negedge clock);
    swapAck = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ready = 1'b0; dataIn = '0; isTrigger = 1'b0; arm = 1'b0;
    stop = 1'b0; singleShot = 1'b1; pretrigger = '0; swapAck = 1'b0;
    readChannel = '0; readAddress = '0;
    repeat (3) @(negedge clock);
    chk("rst_state", 32'(captureState), 32'd0);
    chk("rst_frdy", 32'(frameReady), 32'd0);
    chk("rst_dout", 32'($unsigned(dataOut)), 32'd0);
    reset = 1'b0;

    // Basic single shot, P=4, trigger on sample 20, ready gaps.
    samp = 0;
    pulse_arm(4);
    chk("arm_pre", 32'(captureState), 32'd1);
    send(32, 20, 20, 1'b1);
    chk("t1_done", 32'(captureState), 32'd4);
    chk("t1_frdy0", 32'(frameReady), 32'd0);
    @(negedge clock);
    chk("t1_frdy1", 32'(frameReady), 32'd1);
    chk("t1_idle", 32'(captureState), 32'd0);
    read_frame(20, -4, 11);

    // stop+arm together in IDLE: stop wins.
    pulse_ack();
    chk("ack_clr", 32'(frameReady), 32'd0);
    @(negedge clock);
    arm = 1'b1; stop = 1'b1;
    @(negedge clock);
    arm = 1'b0; stop = 1'b0;
    chk("stop_arm", 32'(captureState), 32'd0);

    // P=0: straight to ARMED; arm during POST must be ignored.
    samp = 200;
    pulse_arm(0);
    chk("p0_armed", 32'(captureState), 32'd2);
    send(8, 202, 202, 1'b1);
    pulse_arm(7);
    chk("arm_in_post", 32'(captureState), 32'd3);
    send(10, -1, -1, 1'b1);
    chk("p0_done", 32'(captureState), 32'd4);
    @(negedge clock);
    chk("p0_frdy", 32'(frameReady), 32'd1);
    read_frame(202, 0, 15);

    // P=15: trigger goes straight to DONE.
    pulse_ack();
    samp = 300;
    pulse_arm(15);
    send(15, -1, -1, 1'b1);
    chk("p15_armed", 32'(captureState), 32'd2);
    send(1, 315, 315, 1'b0);
    chk("p15_done", 32'(captureState), 32'd4);
    @(negedge clock);
    chk("p15_frdy", 32'(frameReady), 32'd1);
    read_frame(315, -15, 0);

    // Triggers during PRE are ignored.
    pulse_ack();
    samp = 400;
    pulse_arm(4);
    send(16, 401, 404, 1'b1);
    chk("pretrg_done", 32'(captureState), 32'd4);
    @(negedge clock);
    read_frame(404, -4, 11);

    // Continuous mode: second frame waits in DONE until ack.
    pulse_ack();
    singleShot = 1'b0;
    samp = 100;
    pulse_arm(2);
    send(19, 105, 105, 1'b1);
    chk("c_done_a", 32'(captureState), 32'd4);
    @(negedge clock);
    chk("c_rearm", 32'(captureState), 32'd1);
    chk("c_frdy_a", 32'(frameReady), 32'd1);
    send(20, 125, 125, 1'b1);
    send(3, -1, -1, 1'b0);
    chk("c_hold", 32'(captureState), 32'd4);
    chk("c_hold_frdy", 32'(frameReady), 32'd1);
    read_frame(105, -2, 13);
    pulse_ack();
    chk("c_ack_frdy", 32'(frameReady), 32'd0);
    chk("c_ack_state", 32'(captureState), 32'd4);
    @(negedge clock);
    chk("c_swap_frdy", 32'(frameReady), 32'd1);
    chk("c_swap_state", 32'(captureState), 32'd1);
    read_frame(125, -2, 13);

    // stop during POST keeps the locked frame.
    singleShot = 1'b1;
    samp = 500;
    send(6, 503, 503, 1'b0);
    chk("s_post", 32'(captureState), 32'd3);
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    chk("s_idle", 32'(captureState), 32'd0);
    chk("s_frdy", 32'(frameReady), 32'd1);
    read_frame(125, -2, 13);

    // Reset in the middle of POST.
    samp = 600;
    pulse_arm(3);
    send(8, 604, 604, 1'b0);
    chk("r_post", 32'(captureState), 32'd3);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("r_state", 32'(captureState), 32'd0);
    chk("r_frdy", 32'(frameReady), 32'd0);
    chk("r_dout", 32'($unsigned(dataOut)), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("r_after", 32'(captureState), 32'd0);

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
